// File: rtl/invsqrt_lut_loader.sv
// invsqrt_lut_loader: streams DEPTH inverse-square-root LUT entries from a
// valid/ready source into a BRAM write port, accumulating a checksum of the
// accepted words. When the last entry lands, the checksum is compared against
// the value captured at start, and lut_ready is raised only on a full,
// matching load.
//
// Handshake: a source beat transfers on a rising edge where s_valid and
// s_ready are both 1. s_ready is high only while loading and only when no
// start is being requested in the same cycle. The source may hold s_valid
// low for any number of cycles; the loader simply waits, with no timeout.
module invsqrt_lut_loader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  exp_sum,
  input  logic              s_valid,
  input  logic [WIDTH-1:0]  s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic              lut_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Index of the final table entry; accepting it ends the load so the
  // index never wraps and wr_addr never exceeds DEPTH-1.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] index;
  logic [WIDTH-1:0]  sum;
  logic [WIDTH-1:0]  exp_reg;
  logic              accept;

  // A start request in LOAD takes priority over any beat offered that cycle.
  assign s_ready = (state == ST_LOAD) && !start;
  assign accept  = s_valid && s_ready;
  assign busy    = (state == ST_LOAD) || (state == ST_CHECK);

  // Control FSM, running checksum, beat counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      index     <= '0;
      sum       <= '0;
      exp_reg   <= '0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      lut_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Table is invalid from the moment a reload begins.
            state     <= ST_LOAD;
            index     <= '0;
            sum       <= '0;
            count     <= '0;
            exp_reg   <= exp_sum;
            lut_ready <= 1'b0;
            err       <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (start) begin
            // Abort the partial load and begin again from entry 0.
            index     <= '0;
            sum       <= '0;
            count     <= '0;
            exp_reg   <= exp_sum;
            lut_ready <= 1'b0;
            err       <= 1'b0;
          end else if (accept) begin
            sum   <= sum + s_data;
            count <= count + 1'b1;
            if (index == LAST_IDX) begin
              state <= ST_CHECK;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          // Single verdict cycle; start requests here are ignored.
          state     <= ST_IDLE;
          done      <= 1'b1;
          lut_ready <= (sum == exp_reg);
          err       <= (sum != exp_reg);
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered BRAM write port: one write per accepted beat, one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= index;
        wr_data <= s_data;
      end
    end
  end

endmodule
